// File: rtl/alpha_razor_replay.sv
// alpha_razor_replay: 8-state max-log-MAP forward-metric (alpha) step
// with a Razor shadow check, bounded replay FSM and error counter.
//
// Ports:
//   Clock, nReset          clock, async active-low reset
//   in_valid / in_ready    operand handshake
//   first_step             use initial metrics (-2^(M-1)) instead of alpha_in
//   alpha_in               states 1..7, state k at [k*M-1:(k-1)*M]
//   ba2, ba1ba3, ba1ba2ba3 signed branch metrics
//   err_inject             forces a detected error while checking
//   out_valid / out_ready  result handshake
//   alpha_out              normalised metrics, same packing as alpha_in
//   out_fault              result released with the error still present
//   err_count, cnt_clear   saturating error counter and its clear
module alpha_razor_replay #(
    parameter int N          = 5,
    parameter int M          = 6,
    parameter int RAZOR_BITS = 2,
    parameter int MAX_REPLAY = 3,
    parameter int CNT_W      = 8
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             first_step,
    input  logic [7*M-1:0]   alpha_in,
    input  logic [N-1:0]     ba2,
    input  logic [M:0]       ba1ba3,
    input  logic [M:0]       ba1ba2ba3,
    input  logic             err_inject,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7*M-1:0]   alpha_out,
    output logic             out_fault,
    output logic [CNT_W-1:0] err_count,
    input  logic             cnt_clear
);

    localparam int SW = M + 2;
    localparam int DW = M + 3;
    localparam int RW = $clog2(MAX_REPLAY + 2);
    localparam int RB = RAZOR_BITS;

    localparam logic signed [DW-1:0] SAT_HI = DW'((2 ** (M - 1)) - 1);
    localparam logic signed [DW-1:0] SAT_LO = DW'(-(2 ** (M - 1)));
    localparam logic [M-1:0]         A_INIT = {1'b1, {(M-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_CHECK,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [7*M-1:0] alpha;
        logic [N-1:0]   ba2;
        logic [M:0]     b13;
        logic [M:0]     b123;
    } op_t;

    state_t            state;
    op_t               op_q;
    logic [7*M-1:0]    res_d;
    logic [7*M-1:0]    result_q;
    logic [7*RB-1:0]   msb_d;
    logic [7*RB-1:0]   msb_q;
    logic [7*RB-1:0]   shadow_q;
    logic [RW-1:0]     replay_cnt;
    logic              err_now;

    logic signed [SW-1:0] a [1:7];
    logic signed [SW-1:0] m [1:8];
    logic signed [SW-1:0] c2;
    logic signed [SW-1:0] c13;
    logic signed [SW-1:0] c123;

    function automatic logic signed [SW-1:0] smax(
        input logic signed [SW-1:0] x,
        input logic signed [SW-1:0] y
    );
        return (x > y) ? x : y;
    endfunction

    function automatic logic [M-1:0] sat(input logic signed [DW-1:0] d);
        if (d > SAT_HI)
            return SAT_HI[M-1:0];
        else if (d < SAT_LO)
            return SAT_LO[M-1:0];
        else
            return d[M-1:0];
    endfunction

    // Datapath: purely combinational from the held operands, so a replay
    // recomputes exactly the same transaction.
    always_comb begin
        for (int k = 1; k <= 7; k++)
            a[k] = SW'($signed(op_q.alpha[(k-1)*M +: M]));
        c2   = SW'($signed(op_q.ba2));
        c13  = SW'($signed(op_q.b13));
        c123 = SW'($signed(op_q.b123));

        m[1] = smax('0, a[1] + c123);
        m[2] = smax(a[2] + c13, a[3] + c2);
        m[3] = smax(a[4] + c2, a[5] + c13);
        m[4] = smax(a[7], a[6] + c123);
        m[5] = smax(c123, a[1]);
        m[6] = smax(a[2] + c2, a[3] + c13);
        m[7] = smax(a[4] + c13, a[5] + c2);
        m[8] = smax(a[6], a[7] + c123);

        res_d = '0;
        for (int k = 1; k <= 7; k++)
            res_d[(k-1)*M +: M] = sat(DW'(m[k+1]) - DW'(m[1]));
    end

    always_comb begin
        msb_d = '0;
        msb_q = '0;
        for (int k = 1; k <= 7; k++) begin
            msb_d[(k-1)*RB +: RB] = res_d[k*M-1 -: RB];
            msb_q[(k-1)*RB +: RB] = result_q[k*M-1 -: RB];
        end
    end

    // Shadow latch stays open through the high phase, so a late-settling
    // datapath shows up as a difference against the edge-captured result.
    always_latch begin
        if (!nReset)
            shadow_q <= '0;
        else if (Clock)
            shadow_q <= msb_d;
    end

    assign err_now = (state == S_CHECK) &&
                     ((|(shadow_q ^ msb_q)) || err_inject);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_fault  <= 1'b0;
            alpha_out  <= '0;
            op_q       <= '0;
            result_q   <= '0;
            replay_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q.alpha <= first_step ? {7{A_INIT}} : alpha_in;
                        op_q.ba2   <= ba2;
                        op_q.b13   <= ba1ba3;
                        op_q.b123  <= ba1ba2ba3;
                        replay_cnt <= '0;
                        in_ready   <= 1'b0;
                        state      <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    result_q <= res_d;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (!err_now) begin
                        alpha_out <= result_q;
                        out_fault <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (replay_cnt < RW'(MAX_REPLAY)) begin
                        replay_cnt <= replay_cnt + 1'b1;
                        state      <= S_COMPUTE;
                    end else begin
                        alpha_out <= result_q;
                        out_fault <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            err_count <= '0;
        else if (cnt_clear)
            err_count <= '0;
        else if (err_now && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_alpha_razor_replay.sv
// Self-checking bench for alpha_razor_replay: directed vectors, replay
// corner cases, randomized transactions against a behavioural model.
module tb_alpha_razor_replay;

    localparam int N  = 5;
    localparam int M  = 6;
    localparam int CW = 8;
    localparam int AW = 7 * M;

    logic          Clock = 1'b0;
    logic          nReset = 1'b1;
    logic          in_valid = 1'b0;
    logic          first_step = 1'b0;
    logic          err_inject = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [AW-1:0] alpha_in = '0;
    logic [N-1:0]  ba2 = '0;
    logic [M:0]    ba1ba3 = '0;
    logic [M:0]    ba1ba2ba3 = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_fault;
    logic [AW-1:0] alpha_out;
    logic [CW-1:0] err_count;

    int nchk = 0;
    int nerr = 0;

    always #5 Clock = ~Clock;

    alpha_razor_replay #(
        .N(N), .M(M), .RAZOR_BITS(2), .MAX_REPLAY(3), .CNT_W(CW)
    ) dut (
        .Clock(Clock), .nReset(nReset),
        .in_valid(in_valid), .in_ready(in_ready),
        .first_step(first_step), .alpha_in(alpha_in),
        .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
        .err_inject(err_inject),
        .out_valid(out_valid), .out_ready(out_ready),
        .alpha_out(alpha_out), .out_fault(out_fault),
        .err_count(err_count), .cnt_clear(cnt_clear)
    );

    typedef struct {
        logic [AW-1:0] ain;
        logic [N-1:0]  b2;
        logic [M:0]    b13;
        logic [M:0]    b123;
        logic          first;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sx(input logic [M:0] v, input int w);
        int r;
        r = int'(v);
        if (v[w-1]) r = r - (1 << w);
        return r;
    endfunction

    function automatic int mx(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [AW-1:0] pk(input int s1, input int s2,
        input int s3, input int s4, input int s5, input int s6,
        input int s7);
        int s[7];
        logic [AW-1:0] r;
        s = '{s1, s2, s3, s4, s5, s6, s7};
        r = '0;
        for (int k = 0; k < 7; k++) r[k*M +: M] = M'(s[k]);
        return r;
    endfunction

    // Reference: alpha metrics from the trellis equations in plain ints.
    function automatic logic [AW-1:0] model(input logic [AW-1:0] ain,
        input logic [N-1:0] b2, input logic [M:0] b13,
        input logic [M:0] b123, input logic first);
        int a[8];
        int mm[9];
        int c2, c13, c123, d, hi, lo;
        logic [AW-1:0] r;
        hi = (1 << (M - 1)) - 1;
        lo = -(1 << (M - 1));
        a[0] = 0;
        for (int k = 1; k <= 7; k++)
            a[k] = first ? lo : sx(ain[(k-1)*M +: M], M);
        c2   = sx(b2, N);
        c13  = sx(b13, M + 1);
        c123 = sx(b123, M + 1);
        mm[0] = 0;
        mm[1] = mx(0, a[1] + c123);
        mm[2] = mx(a[2] + c13, a[3] + c2);
        mm[3] = mx(a[4] + c2, a[5] + c13);
        mm[4] = mx(a[7], a[6] + c123);
        mm[5] = mx(c123, a[1]);
        mm[6] = mx(a[2] + c2, a[3] + c13);
        mm[7] = mx(a[4] + c13, a[5] + c2);
        mm[8] = mx(a[6], a[7] + c123);
        r = '0;
        for (int k = 1; k <= 7; k++) begin
            d = mm[k+1] - mm[1];
            if (d > hi) d = hi;
            if (d < lo) d = lo;
            r[(k-1)*M +: M] = M'(d);
        end
        return r;
    endfunction

    // mode: 0 clean, 1 inject in first check, 2 inject throughout
    task automatic run(input string nm, input vec_t v, input int mode,
                       input int hold, input bit clr,
                       input logic [AW-1:0] exp_out, input int exp_lat,
                       input logic exp_fault);
        int lat;
        logic [AW-1:0] got;
        alpha_in   = v.ain;
        ba2        = v.b2;
        ba1ba3     = v.b13;
        ba1ba2ba3  = v.b123;
        first_step = v.first;
        in_valid   = 1'b1;
        err_inject = (mode == 2);
        @(posedge Clock); #1;
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (mode == 1 && lat == 1) err_inject = 1'b1;
            if (mode == 1 && lat == 3) err_inject = 1'b0;
            cnt_clear = clr && (lat == 2);
            @(posedge Clock); #1;
            lat++;
        end
        err_inject = 1'b0;
        cnt_clear  = 1'b0;
        chk({nm, " out_valid"}, out_valid, 1);
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " alpha_out"}, alpha_out, exp_out);
        chk({nm, " out_fault"}, out_fault, exp_fault);
        got = alpha_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock); #1;
            chk({nm, " hold valid"}, out_valid, 1);
            chk({nm, " hold data"}, alpha_out, got);
            chk({nm, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
        chk({nm, " valid drop"}, out_valid, 0);
        chk({nm, " in_ready back"}, in_ready, 1);
        chk({nm, " data kept"}, alpha_out, exp_out);
    endtask

    initial begin
        vec_t rv;
        int mode, lat, expc;
        bit seen;

        vt[0] = '{pk(0, 0, 0, 0, 0, 0, 0), 5'd1, 7'd2, 7'd3, 1'b0,
                  pk(-1, -1, 0, 0, -1, -1, 0)};
        vt[1] = '{pk(-32, 31, 31, 0, 0, 0, 0), 5'd0, 7'd63, 7'h40, 1'b0,
                  pk(31, 31, 0, -32, 31, 31, 0)};
        vt[2] = '{pk(21, -5, 13, 7, -9, 30, 2), 5'd0, 7'd0, 7'd0, 1'b1,
                  pk(-32, -32, -32, 0, -32, -32, -32)};
        vt[3] = '{pk(31, -32, -32, -32, -32, -32, -32), 5'd0, 7'd0,
                  7'd63, 1'b0, pk(-32, -32, -32, -31, -32, -32, -32)};

        #1 nReset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset alpha_out", alpha_out, 0);
        chk("reset err_count", err_count, 0);
        chk("reset out_fault", out_fault, 0);
        nReset = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 4; i++) begin
            run($sformatf("vec%0d", i), vt[i], 0, 0, 0, vt[i].exp, 3, 0);
            chk($sformatf("vec%0d model", i),
                model(vt[i].ain, vt[i].b2, vt[i].b13, vt[i].b123,
                      vt[i].first), vt[i].exp);
        end
        chk("clean err_count", err_count, 0);

        run("single", vt[0], 1, 0, 0, vt[0].exp, 5, 0);
        chk("single err_count", err_count, 1);

        cnt_clear = 1'b1;
        @(posedge Clock); #1;
        cnt_clear = 1'b0;
        chk("clear err_count", err_count, 0);

        run("persist", vt[0], 2, 0, 0, vt[0].exp, 9, 1);
        chk("persist err_count", err_count, 4);

        run("backpressure", vt[1], 0, 10, 0, vt[1].exp, 3, 0);

        expc = 4;
        for (int i = 0; i < 40; i++) begin
            rv.ain   = AW'({$urandom(), $urandom()});
            rv.b2    = N'($urandom());
            rv.b13   = (M + 1)'($urandom());
            rv.b123  = (M + 1)'($urandom());
            rv.first = ($urandom_range(0, 3) == 0);
            rv.exp   = model(rv.ain, rv.b2, rv.b13, rv.b123, rv.first);
            mode = $urandom_range(0, 2);
            lat  = (mode == 0) ? 3 : (mode == 1) ? 5 : 9;
            expc += (mode == 0) ? 0 : (mode == 1) ? 1 : 4;
            run($sformatf("rand%0d", i), rv, mode, $urandom_range(0, 2),
                0, rv.exp, lat, mode == 2);
            chk($sformatf("rand%0d err_count", i), err_count, expc);
        end

        for (int i = 0; i < 64; i++) begin
            run("satfill", vt[3], 2, 0, 0, vt[3].exp, 9, 1);
            expc = (expc + 4 > 255) ? 255 : expc + 4;
        end
        chk("saturated err_count", err_count, expc);
        chk("saturated at max", err_count, 255);

        run("clear+err", vt[0], 1, 0, 1, vt[0].exp, 5, 0);
        chk("clear priority", err_count, 0);

        run("single2", vt[3], 1, 0, 0, vt[3].exp, 5, 0);
        chk("single2 err_count", err_count, 1);

        alpha_in   = vt[1].ain;
        ba2        = vt[1].b2;
        ba1ba3     = vt[1].b13;
        ba1ba2ba3  = vt[1].b123;
        first_step = 1'b0;
        in_valid   = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        #1 nReset = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 1);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset alpha_out", alpha_out, 0);
        chk("midreset err_count", err_count, 0);
        chk("midreset out_fault", out_fault, 0);
        @(negedge Clock);
        nReset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge Clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no valid after reset", seen, 0);
        chk("idle in_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
